fifo_drain: RTL
===============

# fifo_drain

Read-side consumer for the synchronous `Fifo` block. It pops words through the FIFO's `read_in`/`empty_out` interface, absorbs the memory read latency, and presents them downstream as a valid/ready stream through a 2-entry output buffer. It sits between any `Fifo` instance and a stream sink that may apply backpressure. A flush command drains and discards the FIFO contents.

## Interface
- `WIDTH_BYTES`, 4: word width in bytes; must equal the connected FIFO's `FIFO_WIDTH_BYTES`.
- `SHOWAHEAD`, 0: must equal the FIFO's `SHOWAHEAD`.
  - 0: `fifo_read_data_in` is valid in the cycle after `fifo_read_out`.
  - 1: `fifo_read_data_in` is valid in the same cycle as `fifo_read_out`.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset; assert (0) at any time, deassert synchronously to `clk`.
- `fifo_empty_in` input 1: the FIFO's `empty_out`.
- `fifo_read_out` output 1: the FIFO's `read_in`; pop request.
- `fifo_read_data_in` input WIDTH_BYTES*8: the FIFO's `read_data_out`.
- `out_valid_out` output 1: the head buffer entry is valid.
- `out_data_out` output WIDTH_BYTES*8: the head buffer entry.
- `out_ready_in` input 1: the sink accepts the word this cycle.
- `flush_in` input 1: one-cycle request to discard the buffer and drain the FIFO.
- `flush_done_out` output 1: one-cycle pulse when the flush completes.
- `delivered_count_out` output 16: number of words accepted by the sink; wraps at 2^16.
- `debugen_in` input 1: enables the trace; see Configuration.

## Operation
- **State.**
  - FSM state: RUN or FLUSH.
  - `occ` in 0..2: number of valid buffer entries; entry 0 is the head.
  - `inflight` flag: used only when SHOWAHEAD=0; set while a read has been issued and its data has not yet been captured.
- **Pop and free space.**
  - `pop` = `out_valid_out && out_ready_in`.
  - `space` = 2 − `occ` − `inflight` + `pop`. Width is 3 bits; the result never goes negative.
- **RUN state.**
  - `fifo_read_out` = `!fifo_empty_in && space > 0`. This is combinational from registered state, `fifo_empty_in` and `out_ready_in`.
  - `out_valid_out` = (`occ` > 0).
  - `out_data_out` = entry 0.
- **Buffer update on each edge.**
  - On a pop, entry 1 shifts to entry 0.
  - A captured word is written to the first free slot after the shift.
  - `occ` changes by (+1 if a word is captured) − (1 if `pop`).
  - A capture and a pop in the same cycle leave `occ` unchanged.
- **Capture condition.**
  - SHOWAHEAD=1: capture when `fifo_read_out` is high.
  - SHOWAHEAD=0: capture when `inflight` is high; `inflight` <= `fifo_read_out`.
- **Counter.** `delivered_count_out` increments on every `pop` and wraps from 0xFFFF to 0.
- **Entering FLUSH.** `flush_in` high in RUN moves the FSM to FLUSH on the next edge.
  - `occ` is cleared to 0.
  - A pop in that same cycle still counts.
- **FLUSH state.**
  - `out_valid_out` is 0.
  - `fifo_read_out` = `!fifo_empty_in`.
  - Returned data is discarded, not captured.
  - `inflight` is tracked as in RUN.
- **Leaving FLUSH.** When `fifo_empty_in` is high and `inflight` is 0, the FSM returns to RUN on the next edge and `flush_done_out` pulses for one cycle.
- **Ignored input.** `flush_in` is ignored while in FLUSH.
- **Reset values.**
  - Outputs: `fifo_read_out` 0, `out_valid_out` 0, `out_data_out` 0, `flush_done_out` 0, `delivered_count_out` 0.
  - Internal: state RUN, `occ` 0, `inflight` 0.
  - `fifo_read_out` is forced to 0 while `reset` is asserted.
- **Reset mid-read.** An in-flight read is abandoned; the FIFO has already advanced its pointer, so that word is lost by design.
- **FIFO protocol.** `fifo_read_out` is never asserted while `fifo_empty_in` is high.

## Timing
- **Latency**, from `fifo_read_out` high in cycle N to `out_valid_out` high:
  - SHOWAHEAD=0: cycle N+2.
  - SHOWAHEAD=1: cycle N+1.
- **Throughput.** One word per cycle sustained in both modes while `out_ready_in` stays high and the FIFO is non-empty.
- **Backpressure.**
  - With `out_ready_in` low, at most 2 words are ever buffered or in flight.
  - No word is dropped or duplicated.
  - `out_data_out` is stable while `out_valid_out && !out_ready_in`.
- **Flush timing.**
  - Minimum flush with an empty FIFO: `flush_in` in cycle N, FLUSH during N+1, `flush_done_out` in cycle N+2.
  - With SHOWAHEAD=0 and a read in flight, `flush_done_out` is delayed one more cycle.

## Configuration
- `FIFO_DRAIN_DEBUG_EN` defined:
  - When `debugen_in` is high, each cycle `$write` prints state, `occ`, `inflight`, `fifo_read_out`, `pop` and `out_data_out`, prefixed with `%m`.
  - Any capture while `occ`==2 with no pop prints "buffer overflow" and calls `$finish`.
- `FIFO_DRAIN_DEBUG_EN` undefined: no trace and no checks; `debugen_in` is unused.

## Test plan
- **Basic stream.** FIFO loaded with 0x11, 0x22, 0x33, 0x44, `out_ready_in`=1, SHOWAHEAD=0 → `out_data_out` = 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting 2 cycles after the first `fifo_read_out`; `delivered_count_out`=4.
- **Backpressure.** 8 words, `out_ready_in` toggled 1,0,0,1,… in both SHOWAHEAD modes → all 8 words in order, no `fifo_read_out` while 2 words are held, `out_data_out` stable during stalls.
- **Empty FIFO.** `fifo_empty_in`=1 throughout → `fifo_read_out` never 1 and `out_valid_out` stays 0.
- **Flush.** Flush with 5 words in the FIFO and 2 buffered → `out_valid_out` drops the next cycle, 5 reads are discarded, `flush_done_out` pulses once, then newly written 0xAA streams normally.
- **Counter wrap.** `delivered_count_out` preloaded to 0xFFFE via 65534 transfers, then 3 more → value reads 0x0001.
- **Async reset.** `reset` driven low mid-stream between clock edges → all outputs 0 immediately; after release, stream resumes from the next FIFO word.

Source files
------------

// File: rtl/fifo_drain.sv
// fifo_drain
//   Read-side consumer for the synchronous Fifo block. It pops words through
//   the FIFO read interface, absorbs the memory read latency and presents the
//   words downstream as a valid/ready stream through a 2-entry output buffer.
//   A flush command discards the buffer and drains the FIFO.
//
// Parameters
//   WIDTH_BYTES : word width in bytes (must match the FIFO)
//   SHOWAHEAD   : 0 = read data valid the cycle after the pop request,
//                 1 = read data valid in the same cycle as the pop request
//
// Ports
//   clk                 : clock, all state changes on the rising edge
//   reset               : asynchronous active-low reset
//   fifo_empty_in       : FIFO empty flag
//   fifo_read_out       : FIFO pop request
//   fifo_read_data_in   : FIFO read data
//   out_valid_out       : head buffer entry valid
//   out_data_out        : head buffer entry
//   out_ready_in        : sink accepts the head word this cycle
//   flush_in            : one-cycle request to discard buffer and drain FIFO
//   flush_done_out      : one-cycle pulse when the flush completes
//   delivered_count_out : words accepted by the sink, wraps at 2^16
//   debugen_in          : enables the cycle trace (debug build only)
//
// Build option
//   FIFO_DRAIN_DEBUG_EN : when defined, adds a per-cycle trace gated by
//                         debugen_in and a buffer overflow check.

module fifo_drain #(
  parameter int WIDTH_BYTES = 4,
  parameter int SHOWAHEAD   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty_in,
  output logic                     fifo_read_out,
  input  logic [WIDTH_BYTES*8-1:0] fifo_read_data_in,
  output logic                     out_valid_out,
  output logic [WIDTH_BYTES*8-1:0] out_data_out,
  input  logic                     out_ready_in,
  input  logic                     flush_in,
  output logic                     flush_done_out,
  output logic [15:0]              delivered_count_out,
  input  logic                     debugen_in
);

  localparam int W = WIDTH_BYTES * 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [1:0]     occ;
  logic [1:0]     occ_next;
  logic           inflight;
  logic           inflight_next;
  logic [W-1:0]   entry0;
  logic [W-1:0]   entry1;
  logic [W-1:0]   entry0_next;
  logic [W-1:0]   entry1_next;
  logic           flush_done;
  logic           done_next;
  logic [15:0]    count;
  logic           pop;
  logic           capture;
  logic           read_req;
  logic [2:0]     space;
  logic [1:0]     slot;

  // Next-state, pop request and capture decisions. Free space counts the
  // word already requested but not yet returned, so the buffer can never be
  // over-subscribed; a pop this cycle frees a slot in time for a new request.
  always_comb begin
    state_next    = state;
    done_next     = 1'b0;
    read_req      = 1'b0;
    capture       = 1'b0;
    pop           = (state == RUN) && (occ != 2'd0) && out_ready_in;
    space         = 3'd2 - {1'b0, occ} - {2'b00, inflight} + {2'b00, pop};
    case (state)
      RUN: begin
        read_req = !fifo_empty_in && (space != 3'd0);
        capture  = (SHOWAHEAD != 0) ? read_req : inflight;
        if (flush_in) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Returned words are discarded; only wait for the FIFO to run dry
        // and for any outstanding read to come back.
        read_req = !fifo_empty_in;
        if (fifo_empty_in && !inflight) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    inflight_next = (SHOWAHEAD != 0) ? 1'b0 : read_req;
  end

  // Output buffer update: shift on pop, then drop a captured word into the
  // first free slot after the shift. Entering FLUSH discards the buffer.
  always_comb begin
    entry0_next = entry0;
    entry1_next = entry1;
    slot        = occ - {1'b0, pop};
    if (pop) begin
      entry0_next = entry1;
    end
    if (capture) begin
      if (slot == 2'd0) begin
        entry0_next = fifo_read_data_in;
      end else begin
        entry1_next = fifo_read_data_in;
      end
    end
    occ_next = occ + {1'b0, capture} - {1'b0, pop};
    if ((state == RUN) && flush_in) begin
      occ_next = 2'd0;
    end
  end

  // State, buffer, flush-done pulse and delivered counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      entry0     <= '0;
      entry1     <= '0;
      flush_done <= 1'b0;
      count      <= 16'd0;
    end else begin
      state      <= state_next;
      occ        <= occ_next;
      inflight   <= inflight_next;
      entry0     <= entry0_next;
      entry1     <= entry1_next;
      flush_done <= done_next;
      count      <= count + {15'd0, pop};
    end
  end

  // The pop request is gated by reset so the FIFO never advances while
  // this block is held in reset.
  assign fifo_read_out       = read_req && reset;
  assign out_valid_out       = (state == RUN) && (occ != 2'd0);
  assign out_data_out        = entry0;
  assign flush_done_out      = flush_done;
  assign delivered_count_out = count;

`ifdef FIFO_DRAIN_DEBUG_EN
  // Cycle trace and overflow guard for bring-up.
  always @(posedge clk) begin
    if (reset) begin
      if (debugen_in) begin
        $write("%m: state=%s occ=%0d inflight=%0b read=%0b pop=%0b data=0x%h\n",
               state.name(), occ, inflight, fifo_read_out, pop, out_data_out);
      end
      if (capture && (occ == 2'd2) && !pop) begin
        $display("%m: buffer overflow");
        $finish;
      end
    end
  end
`else
  logic unused_debugen;
  assign unused_debugen = debugen_in;
`endif

endmodule
